// File: rtl/core_pipe_ctrl_pkg.sv
// rtl/core_pipe_ctrl_pkg.sv - shared hold levels, opcodes and FSM states for the pipe sequencer
package core_pipe_ctrl_pkg;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;

  typedef enum logic [1:0] {
    PIPE_IDLE     = 2'd0,
    PIPE_FLUSH    = 2'd1,
    PIPE_BUS_WAIT = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/core_hazard_det.sv
// rtl/core_hazard_det.sv - combinational load-use hazard compare between EX and ID
import core_pipe_ctrl_pkg::*;

module core_hazard_det (
  input  logic [6:0] opcode_ex,
  input  logic       reg_we_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_re_id,
  input  logic       rs2_re_id,
  output logic       load_use
);

  // A load in EX whose destination feeds an ID operand needs a replay; x0 never hazards.
  always_comb begin
    load_use = (opcode_ex == INST_TYPE_L) && reg_we_ex && (rd_ex != 5'd0) &&
               ((rs1_re_id && (rs1_id == rd_ex)) || (rs2_re_id && (rs2_id == rd_ex)));
  end

endmodule

// File: rtl/core_pipe_ctrl.sv
// rtl/core_pipe_ctrl.sv - pipeline sequencer: flush, load-use replay and bus-wait freeze with timeout trap
import core_pipe_ctrl_pkg::*;

module core_pipe_ctrl #(
  parameter int          FLUSH_CYCLES = 1,
  parameter int          BUS_TIMEOUT  = 255,
  parameter logic [31:0] TRAP_ADDR    = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_req_in,
  input  logic [31:0] jump_addr_in,
  input  logic [6:0]  opcode_ex_in,
  input  logic        reg_we_ex_in,
  input  logic [4:0]  rd_ex_in,
  input  logic [4:0]  rs1_id_in,
  input  logic [4:0]  rs2_id_in,
  input  logic        rs1_re_id_in,
  input  logic        rs2_re_id_in,
  input  logic [31:0] inst_addr_id_in,
  input  logic        mem_busy_in,
  output logic [2:0]  hold_flag_out,
  output logic        stall_out,
  output logic        jump_flag_out,
  output logic [31:0] jump_addr_out,
  output logic        bus_err_out
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam int TCNT_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LIMIT   = TCNT_W'(BUS_TIMEOUT);

  pipe_state_e       state, state_nx;
  logic [FCNT_W-1:0] fcnt, fcnt_nx;
  logic [TCNT_W-1:0] tcnt, tcnt_nx;
  logic              load_use;
  logic              idle_eval;
  logic              redirect;
  logic [31:0]       redirect_addr;

  core_hazard_det u_hazard (
    .opcode_ex (opcode_ex_in),
    .reg_we_ex (reg_we_ex_in),
    .rd_ex     (rd_ex_in),
    .rs1_id    (rs1_id_in),
    .rs2_id    (rs2_id_in),
    .rs1_re_id (rs1_re_id_in),
    .rs2_re_id (rs2_re_id_in),
    .load_use  (load_use)
  );

  // State and counter registers; reset returns to IDLE with nothing pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PIPE_IDLE;
      fcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      tcnt  <= tcnt_nx;
    end
  end

  // Next state and outputs; the first cycle of any event is decoded here with zero latency.
  always_comb begin
    state_nx      = state;
    fcnt_nx       = fcnt;
    tcnt_nx       = tcnt;
    hold_flag_out = HOLD_NONE;
    stall_out     = 1'b0;
    jump_flag_out = 1'b0;
    jump_addr_out = 32'd0;
    bus_err_out   = 1'b0;
    idle_eval     = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'd0;

    case (state)
      PIPE_FLUSH: begin
        if (mem_busy_in) begin
          // Bus wait wins: freeze everything, bubble count paused.
          stall_out = 1'b1;
        end else if (jump_req_in) begin
          redirect      = 1'b1;
          redirect_addr = jump_addr_in;
        end else begin
          // ID holds a wrong-path instruction, so load-use is ignored here.
          hold_flag_out = HOLD_ID;
          fcnt_nx       = fcnt - 1'b1;
          if (fcnt_nx == '0) state_nx = PIPE_IDLE;
        end
      end
      PIPE_BUS_WAIT: begin
        if (mem_busy_in) begin
          if (tcnt == TCNT_LIMIT) begin
            bus_err_out   = 1'b1;
            redirect      = 1'b1;
            redirect_addr = TRAP_ADDR;
            tcnt_nx       = '0;
          end else begin
            stall_out = 1'b1;
            tcnt_nx   = tcnt + 1'b1;
          end
        end else begin
          // Bus released: service whatever IDLE would see this same cycle.
          tcnt_nx   = '0;
          state_nx  = PIPE_IDLE;
          idle_eval = 1'b1;
        end
      end
      default: idle_eval = 1'b1;
    endcase

    if (idle_eval) begin
      if (mem_busy_in) begin
        stall_out = 1'b1;
        state_nx  = PIPE_BUS_WAIT;
        tcnt_nx   = TCNT_W'(1);
      end else if (jump_req_in) begin
        redirect      = 1'b1;
        redirect_addr = jump_addr_in;
      end else if (load_use) begin
        // Replay: refetch the ID instruction, single cycle, no flush window.
        jump_flag_out = 1'b1;
        jump_addr_out = inst_addr_id_in;
        hold_flag_out = HOLD_ID;
      end
    end

    // Jumps and the bus trap share the same redirect-then-flush behaviour.
    if (redirect) begin
      jump_flag_out = 1'b1;
      jump_addr_out = redirect_addr;
      hold_flag_out = HOLD_ID;
      fcnt_nx       = FLUSH_RELOAD;
      state_nx      = (FLUSH_RELOAD == '0) ? PIPE_IDLE : PIPE_FLUSH;
    end

    if (rst) begin
      state_nx      = PIPE_IDLE;
      fcnt_nx       = '0;
      tcnt_nx       = '0;
      hold_flag_out = HOLD_NONE;
      stall_out     = 1'b0;
      jump_flag_out = 1'b0;
      jump_addr_out = 32'd0;
      bus_err_out   = 1'b0;
    end
  end

endmodule
